// File: rtl/draw_command_queue_if.sv
// Command-queue bus: SPI byte input, show-ahead entry output and status.
// master drives the byte stream and the renderer handshake; slave is the queue.
interface draw_command_queue_if #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SPRITE_ID_W = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                   cs_active;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_eof;
  logic [SPRITE_ID_W-1:0] out_sprite;
  logic [15:0]            out_x;
  logic [15:0]            out_y;
  logic [7:0]             out_flags;
  logic [CNT_W-1:0]       count;
  logic                   overflow;
  logic                   clear_ovf;

  modport master (
    output cs_active, byte_valid, byte_data, out_ready, clear_ovf,
    input  out_valid, out_eof, out_sprite, out_x, out_y, out_flags, count, overflow
  );

  modport slave (
    input  cs_active, byte_valid, byte_data, out_ready, clear_ovf,
    output out_valid, out_eof, out_sprite, out_x, out_y, out_flags, count, overflow
  );
endinterface

// File: rtl/draw_command_queue.sv
// Decodes the resynchronised SPI byte stream into draw/frame-marker entries
// and buffers them in a show-ahead FIFO for the sprite renderer.
module draw_command_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SPRITE_ID_W = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  draw_command_queue_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SKIP, DRAW} state_t;

  typedef struct packed {
    logic                   eof;
    logic [SPRITE_ID_W-1:0] sprite;
    logic [15:0]            x;
    logic [15:0]            y;
    logic [7:0]             flags;
  } entry_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [9:0]             skip_q, skip_d;
  logic [SPRITE_ID_W-1:0] sprite_q, sprite_d;
  logic [7:0]             xh_q, xh_d;
  logic [7:0]             xl_q, xl_d;
  logic [7:0]             yh_q, yh_d;
  logic [7:0]             yl_q, yl_d;

  entry_t                 mem_q [DEPTH];
  entry_t                 mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic                   accept;
  logic                   push;
  entry_t                 push_entry;
  logic                   pop;
  logic                   full;
  logic                   wr_en;
  entry_t                 head;

  assign accept = bus.byte_valid & bus.cs_active;

  // Parser: dropping chip-select abandons any partial command.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    skip_d     = skip_q;
    sprite_d   = sprite_q;
    xh_d       = xh_q;
    xl_d       = xl_q;
    yh_d       = yh_q;
    yl_d       = yl_q;
    push       = 1'b0;
    push_entry = '0;
    if (!bus.cs_active) begin
      state_d = IDLE;
      idx_d   = '0;
      skip_d  = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          case (bus.byte_data)
            8'h00: begin
              state_d = SKIP;
              skip_d  = 10'd513;
            end
            8'h01: begin
              state_d = DRAW;
              idx_d   = '0;
            end
            8'h02: begin
              push           = 1'b1;
              push_entry.eof = 1'b1;
            end
            default: ;
          endcase
        end
        SKIP: begin
          skip_d = skip_q - 10'd1;
          if (skip_q == 10'd1) state_d = IDLE;
        end
        DRAW: begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0: sprite_d = bus.byte_data[SPRITE_ID_W-1:0];
            3'd1: xh_d = bus.byte_data;
            3'd2: xl_d = bus.byte_data;
            3'd3: yh_d = bus.byte_data;
            3'd4: yl_d = bus.byte_data;
            default: begin
              push              = 1'b1;
              push_entry.eof    = 1'b0;
              push_entry.sprite = sprite_q;
              push_entry.x      = {xh_q, xl_q};
              push_entry.y      = {yh_q, yl_q};
              push_entry.flags  = bus.byte_data;
              state_d           = IDLE;
              idx_d             = '0;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = (count_q != '0) & bus.out_ready;
  // A push into a full FIFO survives only when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !wr_en) count_d = count_q - CNT_W'(1);
    if (push && !wr_en)     overflow_d = 1'b1;
    else if (bus.clear_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      skip_q     <= '0;
      sprite_q   <= '0;
      xh_q       <= '0;
      xl_q       <= '0;
      yh_q       <= '0;
      yl_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      skip_q     <= skip_d;
      sprite_q   <= sprite_d;
      xh_q       <= xh_d;
      xl_q       <= xl_d;
      yh_q       <= yh_d;
      yl_q       <= yl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_eof    = head.eof;
  assign bus.out_sprite = head.sprite;
  assign bus.out_x      = head.x;
  assign bus.out_y      = head.y;
  assign bus.out_flags  = head.flags;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_draw_command_queue.sv
// Directed bench for draw_command_queue: expected entries are queued as
// commands are sent and compared against the FIFO head as it is drained.
module tb_draw_command_queue;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SW    = 6;

  typedef struct {
    logic          eof;
    logic [SW-1:0] sp;
    logic [15:0]   x;
    logic [15:0]   y;
    logic [7:0]    f;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t exp_q[$];
  exp_t e;

  draw_command_queue_if #(.DEPTH(DEPTH), .SPRITE_ID_W(SW)) bus ();

  draw_command_queue #(.DEPTH(DEPTH), .SPRITE_ID_W(SW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy, input logic clr);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.out_ready  = rdy;
    bus.clear_ovf  = clr;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.clear_ovf  = 1'b0;
  endtask

  task automatic send_draw(input logic [7:0] sp, input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] f, input logic rdy_last, input logic clr_last);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(sp, 1'b0, 1'b0);
    send_byte(x[15:8], 1'b0, 1'b0);
    send_byte(x[7:0], 1'b0, 1'b0);
    send_byte(y[15:8], 1'b0, 1'b0);
    send_byte(y[7:0], 1'b0, 1'b0);
    send_byte(f, rdy_last, clr_last);
  endtask

  task automatic expect_draw(input logic [7:0] sp, input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] f);
    exp_t t;
    t.eof = 1'b0; t.sp = sp[SW-1:0]; t.x = x; t.y = y; t.f = f;
    exp_q.push_back(t);
  endtask

  task automatic check_head(input string tag, input exp_t t);
    check({tag, "_valid"},  32'(bus.out_valid),  32'd1);
    check({tag, "_eof"},    32'(bus.out_eof),    32'(t.eof));
    check({tag, "_sprite"}, 32'(bus.out_sprite), 32'(t.sp));
    check({tag, "_x"},      32'(bus.out_x),      32'(t.x));
    check({tag, "_y"},      32'(bus.out_y),      32'(t.y));
    check({tag, "_flags"},  32'(bus.out_flags),  32'(t.f));
  endtask

  task automatic drain(input string tag);
    exp_t t;
    while (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      check_head(tag, t);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    check({tag, "_empty_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_empty_count"}, 32'(bus.count),     32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n          = 1'b0;
    bus.cs_active  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.out_ready  = 1'b0;
    bus.clear_ovf  = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.count),     32'd0);
    check("rst_ovf",   32'(bus.overflow),  32'd0);
    check("rst_x",     32'(bus.out_x),     32'd0);
    check("rst_eof",   32'(bus.out_eof),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cs_active = 1'b1;

    // 1: single draw, latency of the show-ahead head
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h2C, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hC8, 1'b0, 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h03;
    check("t1_pre_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check("t1_count", 32'(bus.count), 32'd1);
    expect_draw(8'd5, 16'd300, 16'd200, 8'h03);
    repeat (2) @(negedge clk);
    check("t1_hold_count", 32'(bus.count), 32'd1);
    drain("t1");

    // 2: sprite upload payload is skipped, then a frame marker
    send_byte(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 513; i++) send_byte(8'h01, 1'b0, 1'b0);
    check("t2_skip_count", 32'(bus.count), 32'd0);
    send_byte(8'h02, 1'b0, 1'b0);
    check("t2_count", 32'(bus.count), 32'd1);
    e.eof = 1'b1; e.sp = '0; e.x = '0; e.y = '0; e.f = '0;
    exp_q.push_back(e);
    drain("t2");

    // 3: 17 draws into a 16-deep FIFO; clear_ovf on the dropping edge loses
    for (int i = 0; i < 17; i++) begin
      send_draw(8'(i), 16'(i * 3), 16'(i + 100), 8'(i ^ 8'h5A), 1'b0, (i == 16));
      if (i < 16) expect_draw(8'(i), 16'(i * 3), 16'(i + 100), 8'(i ^ 8'h5A));
    end
    check("t3_count", 32'(bus.count),    32'd16);
    check("t3_ovf",   32'(bus.overflow), 32'd1);
    drain("t3");
    check("t3_ovf_kept", 32'(bus.overflow), 32'd1);
    bus.clear_ovf = 1'b1;
    @(negedge clk);
    bus.clear_ovf = 1'b0;
    check("t3_ovf_clr", 32'(bus.overflow), 32'd0);

    // 4: abort mid-draw, then a full command
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    bus.cs_active = 1'b0;
    send_byte(8'h56, 1'b0, 1'b0);
    bus.cs_active = 1'b1;
    send_draw(8'h07, 16'hFFFF, 16'h0010, 8'h80, 1'b0, 1'b0);
    check("t4_count", 32'(bus.count), 32'd1);
    expect_draw(8'h07, 16'hFFFF, 16'h0010, 8'h80);
    drain("t4");

    // 5: push into a full FIFO with a simultaneous pop
    for (int i = 0; i < 16; i++) begin
      send_draw(8'(i + 20), 16'(i * 7), 16'(16'hF000 + i), 8'(i), 1'b0, 1'b0);
      expect_draw(8'(i + 20), 16'(i * 7), 16'(16'hF000 + i), 8'(i));
    end
    check("t5_full", 32'(bus.count), 32'd16);
    e = exp_q.pop_front();
    check_head("t5_head", e);
    send_draw(8'h2A, 16'h8000, 16'h7FFF, 8'hC3, 1'b1, 1'b0);
    expect_draw(8'h2A, 16'h8000, 16'h7FFF, 8'hC3);
    check("t5_count", 32'(bus.count),    32'd16);
    check("t5_ovf",   32'(bus.overflow), 32'd0);
    drain("t5");

    // 6: reset in the middle of a draw with entries queued
    for (int i = 0; i < 4; i++) send_draw(8'(i), 16'(i), 16'(i), 8'(i), 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    check("t6_pre_count", 32'(bus.count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count", 32'(bus.count),     32'd0);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_ovf",   32'(bus.overflow),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h44, 1'b0, 1'b0);
    check("t6_no_stale", 32'(bus.count), 32'd0);
    send_draw(8'h3F, 16'h1234, 16'hABCD, 8'h55, 1'b0, 1'b0);
    expect_draw(8'h3F, 16'h1234, 16'hABCD, 8'h55);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
